// File: rtl/ofdm_frame_sched.sv
// Frame-length scheduler for the OFDM synchronizer: queues host frame lengths,
// loads one per frame and tracks the output stream to find each frame's end.
module ofdm_frame_sched #(
    parameter int         SYMBOL_LEN      = 80,
    parameter int         MAX_NUM_SYMBOLS = 200,
    parameter int         NSW             = $clog2(MAX_NUM_SYMBOLS + 1),
    parameter int         QUEUE_AWIDTH    = 3,
    parameter logic [7:0] SR_FRAME_LEN    = 8'd132,
    parameter logic [7:0] SR_DEFAULT_LEN  = 8'd133,
    parameter logic [7:0] SR_CTRL         = 8'd134
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_sof,
    output logic [NSW-1:0]          num_symbols,
    output logic                    num_symbols_valid,
    output logic                    frame_active,
    output logic [QUEUE_AWIDTH:0]   queue_count,
    output logic                    overflow,
    output logic [15:0]             reject_cnt,
    output logic [15:0]             abort_cnt
);

    localparam int                  SCW         = $clog2(SYMBOL_LEN);
    localparam int                  DEPTH       = 2 ** QUEUE_AWIDTH;
    localparam logic [NSW-1:0]      MAX_NS      = NSW'(MAX_NUM_SYMBOLS);
    localparam logic [SCW-1:0]      LAST_SAMPLE = SCW'(SYMBOL_LEN - 1);
    localparam logic [QUEUE_AWIDTH:0] FULL_COUNT = (QUEUE_AWIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, RUN} state_t;

    state_t                  state;
    logic [NSW-1:0]          mem [DEPTH];
    logic [QUEUE_AWIDTH-1:0] wr_ptr;
    logic [QUEUE_AWIDTH-1:0] rd_ptr;
    logic [NSW-1:0]          default_len;
    logic                    default_en;
    logic [SCW-1:0]          sample_cnt;
    logic [NSW-1:0]          sym_cnt;

    logic           beat;
    logic           wr_frame;
    logic           wr_default;
    logic           flush;
    logic [NSW-1:0] push_val;
    logic           len_ok;
    logic           default_ok;
    logic           q_empty;
    logic           q_full;
    logic           pop;
    logic           push_try;
    logic           push;

    assign beat       = mon_tvalid & mon_tready;
    assign wr_frame   = set_stb && (set_addr == SR_FRAME_LEN);
    assign wr_default = set_stb && (set_addr == SR_DEFAULT_LEN);
    assign flush      = set_stb && (set_addr == SR_CTRL) && set_data[0];
    assign push_val   = set_data[NSW-1:0];
    assign len_ok     = (push_val != '0) && (push_val <= MAX_NS) && (set_data[31:NSW] == '0);
    assign default_ok = default_en && (default_len != '0) && (default_len <= MAX_NS);
    assign q_empty    = (queue_count == '0);
    assign q_full     = (queue_count == FULL_COUNT);
    assign pop        = !flush && (state == IDLE) && !q_empty;
    assign push_try   = wr_frame && len_ok && !flush;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign push       = push_try && (!q_full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      queue_count <= queue_count + 1'b1;
            else if (pop && !push) queue_count <= queue_count - 1'b1;
            if (push_try && q_full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: queue storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            default_len <= '0;
            default_en  <= 1'b0;
            reject_cnt  <= '0;
        end else begin
            if (wr_default) begin
                default_len <= set_data[NSW-1:0];
                default_en  <= set_data[31];
            end
            if (wr_frame && !len_ok && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            num_symbols       <= MAX_NS;
            num_symbols_valid <= 1'b0;
            frame_active      <= 1'b0;
            sample_cnt        <= '0;
            sym_cnt           <= '0;
            abort_cnt         <= '0;
        end else begin
            num_symbols_valid <= 1'b0;
            if (flush) begin
                state        <= IDLE;
                frame_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!q_empty) begin
                            num_symbols       <= mem[rd_ptr];
                            num_symbols_valid <= 1'b1;
                            state             <= LOAD;
                        end else if (default_ok) begin
                            num_symbols       <= default_len;
                            num_symbols_valid <= 1'b1;
                            state             <= LOAD;
                        end
                    end
                    LOAD: state <= ARMED;
                    ARMED: begin
                        if (beat && mon_sof) begin
                            sample_cnt   <= SCW'(1);
                            sym_cnt      <= '0;
                            frame_active <= 1'b1;
                            state        <= RUN;
                        end
                    end
                    RUN: begin
                        if (beat) begin
                            if (mon_sof) begin
                                // Premature SOF: drop the frame and leave this beat uncounted.
                                if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
                                frame_active <= 1'b0;
                                state        <= IDLE;
                            end else if (sample_cnt == LAST_SAMPLE) begin
                                sample_cnt <= '0;
                                sym_cnt    <= sym_cnt + 1'b1;
                                if ((sym_cnt + 1'b1) == num_symbols) begin
                                    frame_active <= 1'b0;
                                    state        <= IDLE;
                                end
                            end else begin
                                sample_cnt <= sample_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Scenario bench for ofdm_frame_sched: queued lengths are scoreboarded and
// matched against every load pulse, frame spans checked per frame.
module tb_ofdm_frame_sched;

    localparam int         SYMBOL_LEN     = 80;
    localparam logic [7:0] SR_FRAME_LEN   = 8'd132;
    localparam logic [7:0] SR_DEFAULT_LEN = 8'd133;
    localparam logic [7:0] SR_CTRL        = 8'd134;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_sof = 1'b0;
    logic [7:0]  num_symbols;
    logic        num_symbols_valid;
    logic        frame_active;
    logic [3:0]  queue_count;
    logic        overflow;
    logic [15:0] reject_cnt;
    logic [15:0] abort_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_loads = 0;

    logic [7:0] mdl_q[$];
    bit         dflt_en_m = 1'b0;
    logic [7:0] dflt_len_m = 8'd0;

    ofdm_frame_sched dut (
        .clk               (clk),
        .reset             (reset),
        .set_stb           (set_stb),
        .set_addr          (set_addr),
        .set_data          (set_data),
        .mon_tvalid        (mon_tvalid),
        .mon_tready        (mon_tready),
        .mon_sof           (mon_sof),
        .num_symbols       (num_symbols),
        .num_symbols_valid (num_symbols_valid),
        .frame_active      (frame_active),
        .queue_count       (queue_count),
        .overflow          (overflow),
        .reject_cnt        (reject_cnt),
        .abort_cnt         (abort_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Load monitor: each pulse must carry the next queued length or the default.
    initial begin : load_monitor
        logic [7:0] ns_d;
        logic [7:0] exp_ns;
        bit         rst_d;
        bit         vld_d;
        bit         have_exp;
        ns_d  = 8'd0;
        rst_d = 1'b1;
        vld_d = 1'b0;
        forever begin
            @(negedge clk);
            if (num_symbols_valid === 1'b1) begin
                n_loads++;
                have_exp = 1'b1;
                exp_ns   = 8'd0;
                if (mdl_q.size() > 0) exp_ns = mdl_q.pop_front();
                else if (dflt_en_m)   exp_ns = dflt_len_m;
                else                  have_exp = 1'b0;
                n_cmp++;
                if (!have_exp) begin
                    n_err++;
                    $display("FAIL load_unexpected: pulse carrying %0d, required no pulse", num_symbols);
                end else if (num_symbols !== exp_ns) begin
                    n_err++;
                    $display("FAIL load_value: num_symbols=%0d, required %0d", num_symbols, exp_ns);
                end
                n_cmp++;
                if (vld_d) begin
                    n_err++;
                    $display("FAIL load_pulse_width: valid high 2 cycles, required 1");
                end
            end else if (!rst_d) begin
                n_cmp++;
                if (num_symbols !== ns_d) begin
                    n_err++;
                    $display("FAIL num_symbols_stable: changed %0d -> %0d without load", ns_d, num_symbols);
                end
            end
            rst_d = reset;
            vld_d = (num_symbols_valid === 1'b1);
            ns_d  = num_symbols;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic push_len(input logic [31:0] v, input bit accept);
        if (accept) mdl_q.push_back(v[7:0]);
        write_reg(SR_FRAME_LEN, v);
    endtask

    // Sends nsym symbols with random idle gaps; push_mid != 0 pushes that length halfway.
    task automatic send_frame(input int nsym, input int push_mid);
        int total;
        int hi;
        int cyc;
        total = nsym * SYMBOL_LEN;
        hi = 0;
        cyc = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < total; i++) begin
            if (i > 0) begin
                for (int g = 0; g < 3 && $urandom_range(0, 99) < 25; g++) begin
                    mon_tvalid = 1'($urandom_range(0, 1));
                    mon_tready = ~mon_tvalid;
                    mon_sof    = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (frame_active === 1'b1) hi++;
                    cyc++;
                    @(posedge clk);
                    #1;
                end
            end
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_sof    = (i == 0);
            if (push_mid != 0 && i == total / 2) begin
                mdl_q.push_back(8'(push_mid));
                set_stb  = 1'b1;
                set_addr = SR_FRAME_LEN;
                set_data = 32'(push_mid);
            end
            @(negedge clk);
            if (frame_active === 1'b1) hi++;
            cyc++;
            @(posedge clk);
            #1;
            set_stb = 1'b0;
        end
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_sof    = 1'b0;
        @(negedge clk);
        if (frame_active === 1'b1) hi++;
        n_cmp++;
        if (hi != cyc - 1) begin
            n_err++;
            $display("FAIL frame_active_span: %0d cycles high, required %0d (nsym=%0d)", hi, cyc - 1, nsym);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (num_symbols !== 8'd200) begin n_err++; $display("FAIL reset_num_symbols: %0d, required 200", num_symbols); end
        n_cmp++; if (num_symbols_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b, required 0", num_symbols_valid); end
        n_cmp++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL reset_frame_active: %b, required 0", frame_active); end
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL reset_queue_count: %0d, required 0", queue_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: %b, required 0", overflow); end
        n_cmp++; if (reject_cnt !== 16'd0) begin n_err++; $display("FAIL reset_reject_cnt: %0d, required 0", reject_cnt); end
        n_cmp++; if (abort_cnt !== 16'd0) begin n_err++; $display("FAIL reset_abort_cnt: %0d, required 0", abort_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_frames();
        push_len(32'd3, 1'b1);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd1) begin n_err++; $display("FAIL push_latency_count: %0d, required 1", queue_count); end
        @(negedge clk);
        n_cmp++; if (num_symbols_valid !== 1'b1) begin n_err++; $display("FAIL load_latency: valid=%b at N+2, required 1", num_symbols_valid); end
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL pop_count: %0d, required 0", queue_count); end
        push_len(32'd5, 1'b1);
        push_len(32'd2, 1'b1);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd2) begin n_err++; $display("FAIL queued_two: %0d, required 2", queue_count); end
        send_frame(3, 0);
        idle(3);
        send_frame(5, 0);
        idle(3);
        send_frame(2, 0);
        idle(3);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL frames_queue_end: %0d, required 0", queue_count); end
        n_cmp++; if (n_loads != 3) begin n_err++; $display("FAIL frames_load_count: %0d, required 3", n_loads); end
    endtask

    task automatic test_reject();
        int l0;
        l0 = n_loads;
        @(posedge clk);
        #1;
        push_len(32'd0, 1'b0);
        push_len(32'd201, 1'b0);
        push_len(32'h8000_0005, 1'b0);
        idle(6);
        @(negedge clk);
        n_cmp++; if (reject_cnt !== 16'd3) begin n_err++; $display("FAIL reject_cnt: %0d, required 3", reject_cnt); end
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL reject_queue: %0d, required 0", queue_count); end
        n_cmp++; if (n_loads != l0) begin n_err++; $display("FAIL reject_no_load: %0d pulses, required 0", n_loads - l0); end
    endtask

    task automatic test_overflow();
        @(posedge clk);
        #1;
        push_len(32'd1, 1'b1);
        idle(4);
        for (int v = 10; v < 18; v++) push_len(32'(v), 1'b1);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd8) begin n_err++; $display("FAIL full_count: %0d, required 8", queue_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_no_overflow: %b, required 0", overflow); end
        send_frame(1, 0);
        push_len(32'd18, 1'b1);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd8) begin n_err++; $display("FAIL push_pop_full_count: %0d, required 8", queue_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL push_pop_full_overflow: %b, required 0", overflow); end
        idle(2);
        push_len(32'd19, 1'b0);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd8) begin n_err++; $display("FAIL overflow_count: %0d, required 8", queue_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: %b, required 1", overflow); end
        @(posedge clk);
        #1;
        write_reg(SR_CTRL, 32'd1);
        mdl_q.delete();
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL flush_count: %0d, required 0", queue_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL flush_overflow: %b, required 0", overflow); end
        n_cmp++; if (num_symbols !== 8'd10) begin n_err++; $display("FAIL flush_hold: num_symbols=%0d, required 10", num_symbols); end
        idle(4);
    endtask

    task automatic test_default();
        int l0;
        l0 = n_loads;
        write_reg(SR_DEFAULT_LEN, 32'h8000_0004);
        dflt_en_m  = 1'b1;
        dflt_len_m = 8'd4;
        idle(4);
        send_frame(4, 0);
        idle(3);
        send_frame(4, 6);
        write_reg(SR_DEFAULT_LEN, 32'd0);
        dflt_en_m = 1'b0;
        idle(3);
        write_reg(SR_CTRL, 32'd1);
        idle(3);
        @(negedge clk);
        n_cmp++; if (n_loads - l0 != 3) begin n_err++; $display("FAIL default_load_count: %0d, required 3", n_loads - l0); end
        n_cmp++; if (num_symbols !== 8'd6) begin n_err++; $display("FAIL default_then_queue: num_symbols=%0d, required 6", num_symbols); end
    endtask

    task automatic test_abort();
        @(posedge clk);
        #1;
        push_len(32'd5, 1'b1);
        idle(4);
        push_len(32'd7, 1'b1);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        for (int i = 0; i < 151; i++) begin
            mon_sof = (i == 0);
            @(posedge clk);
            #1;
        end
        mon_sof = 1'b1;
        @(negedge clk);
        n_cmp++; if (frame_active !== 1'b1) begin n_err++; $display("FAIL abort_pre_active: %b, required 1", frame_active); end
        @(posedge clk);
        #1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_sof    = 1'b0;
        @(negedge clk);
        n_cmp++; if (abort_cnt !== 16'd1) begin n_err++; $display("FAIL abort_cnt: %0d, required 1", abort_cnt); end
        n_cmp++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL abort_idle: frame_active=%b, required 0", frame_active); end
        idle(3);
        send_frame(7, 0);
        idle(2);
        @(negedge clk);
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL abort_queue_end: %0d, required 0", queue_count); end
        n_cmp++; if (abort_cnt !== 16'd1) begin n_err++; $display("FAIL abort_cnt_after: %0d, required 1", abort_cnt); end
    endtask

    task automatic test_reset_midframe();
        int l0;
        @(posedge clk);
        #1;
        push_len(32'd3, 1'b1);
        idle(4);
        push_len(32'd4, 1'b1);
        push_len(32'd5, 1'b1);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        for (int i = 0; i < 51; i++) begin
            mon_sof = (i == 0);
            @(posedge clk);
            #1;
        end
        mon_sof = 1'b0;
        @(negedge clk);
        n_cmp++; if (frame_active !== 1'b1) begin n_err++; $display("FAIL rst_pre_active: %b, required 1", frame_active); end
        n_cmp++; if (queue_count !== 4'd2) begin n_err++; $display("FAIL rst_pre_count: %0d, required 2", queue_count); end
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_q.delete();
        @(negedge clk);
        n_cmp++; if (num_symbols !== 8'd200) begin n_err++; $display("FAIL rst_mid_num_symbols: %0d, required 200", num_symbols); end
        n_cmp++; if (num_symbols_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: %b, required 0", num_symbols_valid); end
        n_cmp++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL rst_mid_frame_active: %b, required 0", frame_active); end
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL rst_mid_queue_count: %0d, required 0", queue_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_overflow: %b, required 0", overflow); end
        n_cmp++; if (reject_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_reject_cnt: %0d, required 0", reject_cnt); end
        n_cmp++; if (abort_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_abort_cnt: %0d, required 0", abort_cnt); end
        l0 = n_loads;
        idle(20);
        @(negedge clk);
        n_cmp++; if (n_loads != l0) begin n_err++; $display("FAIL rst_mid_no_load: %0d pulses, required 0", n_loads - l0); end
        n_cmp++; if (queue_count !== 4'd0) begin n_err++; $display("FAIL rst_mid_queue_after: %0d, required 0", queue_count); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_reject();
        test_overflow();
        test_default();
        test_abort();
        test_reset_midframe();
        n_cmp++;
        if (mdl_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d loads outstanding, required 0", mdl_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ofdm_frame_sched.md
# ofdm_frame_sched

Per-frame length scheduler for the OFDM synchronizer datapath in the RFNoC OFDM receive block. It holds a short queue of host-supplied frame lengths, written through settings registers, and loads one into the synchronizer's `num_symbols`/`num_symbols_valid` config port before each frame. It then monitors the synchronizer's output stream, counting samples and symbols to find where each frame ends. It reports queue status, rejected writes, overflow, and frames aborted by a premature start-of-frame.

## Interface
Parameters:
- `SYMBOL_LEN`, 80: samples per output symbol (64 + 16 cyclic prefix).
- `MAX_NUM_SYMBOLS`, 200: largest legal frame length in symbols.
- `NSW`, `$clog2(MAX_NUM_SYMBOLS+1)`: width of symbol-count fields.
- `QUEUE_AWIDTH`, 3: queue depth is `2**QUEUE_AWIDTH` entries.
- `SR_FRAME_LEN`, 132: settings address; a write pushes one frame length.
- `SR_DEFAULT_LEN`, 133: settings address; `[NSW-1:0]` is the default length, bit 31 is the default enable.
- `SR_CTRL`, 134: settings address; bit 0 is a self-clearing flush.

Ports:
- `clk` in 1: compute-engine clock. This is the block's only clock.
- `reset` in 1: synchronous, active-high.
- `set_stb` in 1, `set_addr` in 8, `set_data` in 32: settings bus.
- `mon_tvalid` in 1, `mon_tready` in 1, `mon_sof` in 1: taps on the synchronizer output. A beat counts only when `mon_tvalid & mon_tready`.
- `num_symbols` out NSW: frame length presented to the synchronizer.
- `num_symbols_valid` out 1: one-cycle load strobe.
- `frame_active` out 1: high while state is RUN.
- `queue_count` out QUEUE_AWIDTH+1: current queue occupancy.
- `overflow` out 1: sticky; cleared by flush or reset.
- `reject_cnt` out 16, `abort_cnt` out 16: saturating counters.

## Operation
- Push:
  - A write to `SR_FRAME_LEN` takes value `v = set_data[NSW-1:0]`.
  - It is accepted only if `1 <= v <= MAX_NUM_SYMBOLS` and `set_data[31:NSW] == 0`.
  - An out-of-range value increments `reject_cnt` and is not queued.
  - A write while the queue is full is dropped and sets `overflow`.
- State machine: IDLE, LOAD, ARMED, RUN.
- IDLE:
  - If the queue is non-empty, go to LOAD with source = queue head.
  - Otherwise, if the default enable is set and the default length is in range, go to LOAD with source = default.
  - Otherwise stay in IDLE.
- LOAD (exactly one cycle):
  - Register `num_symbols` from the source.
  - Pulse `num_symbols_valid`.
  - Pop the queue if the queue was the source.
  - Go to ARMED.
- ARMED:
  - Wait for a counted beat with `mon_sof = 1`.
  - On that beat, set `sample_cnt = 1` and `sym_cnt = 0`, then go to RUN.
  - Beats without `mon_sof` are ignored.
- RUN:
  - Each counted beat increments `sample_cnt`.
  - When `sample_cnt == SYMBOL_LEN`, wrap `sample_cnt` to 0 and increment `sym_cnt`.
  - When `sym_cnt` reaches `num_symbols`, go to IDLE.
  - A counted beat with `mon_sof = 1` while in RUN aborts the frame: increment `abort_cnt`, go to IDLE, and do not count that beat.
- Flush (a write to `SR_CTRL` with bit 0 set):
  - Empty the queue, clear `overflow`, and force state to IDLE.
  - `num_symbols` holds its last value.
  - Flush takes priority over push and pop in the same cycle.
- Arithmetic:
  - `sample_cnt` is `$clog2(SYMBOL_LEN)` bits wide and `sym_cnt` is NSW bits wide.
  - `reject_cnt` and `abort_cnt` saturate at 16'hFFFF.

## Timing
- Reset values:
  - `num_symbols = MAX_NUM_SYMBOLS`.
  - `num_symbols_valid`, `frame_active`, `queue_count`, `overflow`, `reject_cnt`, `abort_cnt` are all 0.
  - Queue is empty, default enable is 0, state is IDLE.
- Reset mid-frame returns to IDLE and discards all queued entries.
- A push strobed at cycle N is reflected in `queue_count` at N+1.
- From a push into an empty queue with state IDLE: LOAD occurs at N+2, so `num_symbols`/`num_symbols_valid` are visible at N+2.
- `num_symbols` changes only in LOAD and is stable everywhere else.
- Push and pop in the same cycle are both applied; `queue_count` is unchanged. This holds even when the queue is full: the pop frees the slot, so the push is accepted and `overflow` is not set.
- `frame_active` rises the cycle after the SOF beat and falls the cycle after the final beat.
- Back-to-back frames: minimum gap is IDLE→LOAD→ARMED, i.e. 2 cycles after the final beat before the next SOF can be accepted. An SOF arriving earlier is ignored.
- The `mon_*` inputs are observe-only; the block never stalls the stream.

## Test plan
- Push 3, 5, 2 to `SR_FRAME_LEN`, then send three SOF-started frames of 3×80, 5×80, 2×80 beats with random `mon_tvalid` gaps.
  - Expect three `num_symbols_valid` pulses carrying 3, 5, 2.
  - Expect `frame_active` to span exactly each frame.
  - Expect `queue_count` to end at 0.
- Push 0, then 201, then 0x8000_0005 → `reject_cnt = 3`, `queue_count = 0`, no load pulse.
- Push 9 values into the 8-deep queue with the state machine held in ARMED → `queue_count = 8`, `overflow = 1`. Then flush → `queue_count = 0`, `overflow = 0`.
- Set the default (bit 31 plus length 4) with the queue empty, then run two 320-beat frames.
  - Expect a pulse carrying 4 before each frame.
  - Pushing 6 mid-frame makes the next load carry 6.
- With `num_symbols = 5`, send SOF, then 150 beats, then a second SOF → `abort_cnt = 1`, state IDLE, the next queued length is loaded, and the following SOF starts a new frame.
- Assert `reset` during RUN with 2 entries queued → all outputs return to their reset values on the next cycle, the queue is empty, and no load pulse occurs afterward without a new push.
